eth_mmio_regs: RTL and testbench

- CPU-side memory-mapped register block that sits directly upstream of the eth MAC/UDP block.
- Turns 32-bit CPU load/store accesses into eth's configuration inputs, the flat send buffer and the send trigger.
- Exposes eth's receive buffer, receive metadata and link speed as readable registers.
- Owns the receive handshake: sticky rx_valid plus back-pressure via recv_buf_full.

---
 rtl/eth_mmio_pkg.sv | 29 ++
 rtl/eth_mmio_tx_ctrl.sv | 49 ++++
 rtl/eth_mmio_regs.sv | 159 +++++++++++++++
 tb/tb_eth_mmio_regs.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/eth_mmio_pkg.sv
// eth_mmio_pkg: shared register offsets, CTRL/STATUS bit positions, window codes and TX states
package eth_mmio_pkg;
  localparam logic [9:0] REG_CTRL     = 10'h000;
  localparam logic [9:0] REG_STATUS   = 10'h004;
  localparam logic [9:0] REG_MAC_LO   = 10'h008;
  localparam logic [9:0] REG_MAC_HI   = 10'h00C;
  localparam logic [9:0] REG_SELF_IP  = 10'h010;
  localparam logic [9:0] REG_GW_IP    = 10'h014;
  localparam logic [9:0] REG_DEST_IP  = 10'h018;
  localparam logic [9:0] REG_TX_PORTS = 10'h01C;
  localparam logic [9:0] REG_TX_LEN   = 10'h020;
  localparam logic [9:0] REG_RX_PORTS = 10'h024;
  localparam logic [9:0] REG_RX_LEN   = 10'h028;
  localparam logic [9:0] REG_IRQ_EN   = 10'h02C;
  localparam int CTRL_SEND     = 0;
  localparam int CTRL_RX_ACK   = 1;
  localparam int CTRL_CLR_ERR  = 2;
  localparam int CTRL_CLR_DONE = 3;
  localparam int ST_TX_BUSY  = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_OVF   = 2;
  localparam int ST_LEN_ERR  = 3;
  localparam int ST_LINK     = 4;
  localparam int ST_DROP     = 16;
  localparam logic [1:0] WIN_REG  = 2'b00;
  localparam logic [1:0] WIN_SEND = 2'b01;
  localparam logic [1:0] WIN_RECV = 2'b10;
  typedef enum logic [1:0] {TX_IDLE, TX_PULSE, TX_HOLD} tx_state_t;
endpackage

// File: rtl/eth_mmio_tx_ctrl.sv
// eth_mmio_tx_ctrl: send FSM producing the eth trigger pulse, busy window and length error
// Ports: send/clr_err are CTRL write strobes, send_length is the TX_LEN field;
// send_trigger drives eth, tx_busy gates config writes, tx_done pulses on HOLD->IDLE.
module eth_mmio_tx_ctrl
  import eth_mmio_pkg::*;
#(
  parameter int BUF_SIZE    = 1024,
  parameter int TRIG_CYCLES = 4,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic        clr_err,
  input  logic [15:0] send_length,
  output logic        send_trigger,
  output logic        tx_busy,
  output logic        len_err,
  output logic        tx_done
);
  localparam logic [16:0] MAX_LEN = 17'(BUF_SIZE / 8);
  tx_state_t   state, state_n;
  logic [31:0] cnt;
  logic        len_ok;
  assign len_ok = send_length != 16'd0 && {1'b0, send_length} <= MAX_LEN;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= (state_n != state || state == TX_IDLE) ? '0 : cnt + 32'd1;
      len_err <= (send && state == TX_IDLE && !len_ok) ? 1'b1 : clr_err ? 1'b0 : len_err;
    end
  end
  always_comb begin
    state_n = state == TX_IDLE  ? ((send && len_ok) ? TX_PULSE : TX_IDLE) :
              state == TX_PULSE ? ((cnt == 32'(TRIG_CYCLES - 1)) ? TX_HOLD : TX_PULSE) :
              state == TX_HOLD  ? ((cnt == 32'(HOLD_CYCLES - 1)) ? TX_IDLE : TX_HOLD) :
              TX_IDLE;
  end
  // trigger decodes straight from the async-reset state so it drops the moment rst_n falls
  always_comb begin
    send_trigger = state == TX_PULSE;
    tx_busy      = state != TX_IDLE;
    tx_done      = state == TX_HOLD && state_n == TX_IDLE;
  end
endmodule

// File: rtl/eth_mmio_regs.sv
// eth_mmio_regs: CPU MMIO register block feeding the eth MAC/UDP core
// Ports: 32-bit load/store bus (bus_*, 1-cycle registered read), eth config/send outputs,
// eth receive inputs, recv_buf_full back-pressure. Optional ETH_MMIO_IRQ_EN adds irq and IRQ_EN.
module eth_mmio_regs
  import eth_mmio_pkg::*;
#(
  parameter int          BUF_SIZE    = 1024,
  parameter int          TRIG_CYCLES = 4,
  parameter int          HOLD_CYCLES = 4096,
  parameter logic [47:0] DEFAULT_MAC = 48'h00_0A_35_01_02_03,
  parameter logic [31:0] DEFAULT_IP  = 32'hC0A8_0102
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11:0]         bus_addr,
  input  logic                bus_we,
  input  logic                bus_re,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_rvalid,
  output logic [47:0]         self_mac,
  output logic [31:0]         self_ip,
  output logic [31:0]         gateway_ip,
  output logic [31:0]         send_dest_ip,
  output logic [15:0]         send_src_port,
  output logic [15:0]         send_dest_port,
  output logic [15:0]         send_length,
  output logic                send_trigger,
  output logic [BUF_SIZE-1:0] send_buf,
  input  logic [BUF_SIZE-1:0] recv_buf,
  input  logic [15:0]         recv_src_port,
  input  logic [15:0]         recv_dest_port,
  input  logic [15:0]         recv_length,
  input  logic                recv_complete,
  input  logic [1:0]          linkspeed,
`ifdef ETH_MMIO_IRQ_EN
  output logic                irq,
`endif
  output logic                recv_buf_full
);
  localparam int NW = BUF_SIZE / 32;
  localparam int KW = NW > 1 ? $clog2(NW) : 1;
  logic [1:0]    win;
  logic [7:0]    k;
  logic [KW-1:0] ki;
  logic          k_ok;
  logic [9:0]    off;
  logic          wr_reg, ctrl_wr, send, ack, clr;
  logic          tx_busy, len_err, tx_done;
  logic          rx_valid, rx_overflow, drop;
  logic [7:0]    drop_cnt;
  logic [31:0]   status, irq_rd, reg_rd, rd_data;
  logic          unused_ok;
  assign win     = bus_addr[11:10];
  assign k       = bus_addr[9:2];
  assign ki      = k[KW-1:0];
  assign k_ok    = 32'(k) < NW;
  assign off     = {bus_addr[9:2], 2'b00};
  assign wr_reg  = bus_we && win == WIN_REG;
  assign ctrl_wr = wr_reg && off == REG_CTRL;
  assign send    = ctrl_wr && bus_wdata[CTRL_SEND];
  assign ack     = ctrl_wr && bus_wdata[CTRL_RX_ACK];
  assign clr     = ctrl_wr && bus_wdata[CTRL_CLR_ERR];
  // an ack in the same cycle frees the slot before the new packet lands, so no drop
  assign drop    = recv_complete && rx_valid && !ack;
  assign recv_buf_full = rx_valid;
  eth_mmio_tx_ctrl #(
    .BUF_SIZE   (BUF_SIZE),
    .TRIG_CYCLES(TRIG_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .send        (send),
    .clr_err     (clr),
    .send_length (send_length),
    .send_trigger(send_trigger),
    .tx_busy     (tx_busy),
    .len_err     (len_err),
    .tx_done     (tx_done)
  );
  always_comb begin
    status = '0;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVF]     = rx_overflow;
    status[ST_LEN_ERR]    = len_err;
    status[ST_LINK +: 2]  = linkspeed;
    status[ST_DROP +: 8]  = drop_cnt;
  end
  always_comb begin
    reg_rd = off == REG_STATUS   ? status :
             off == REG_MAC_LO   ? self_mac[31:0] :
             off == REG_MAC_HI   ? {16'b0, self_mac[47:32]} :
             off == REG_SELF_IP  ? self_ip :
             off == REG_GW_IP    ? gateway_ip :
             off == REG_DEST_IP  ? send_dest_ip :
             off == REG_TX_PORTS ? {send_dest_port, send_src_port} :
             off == REG_TX_LEN   ? {16'b0, send_length} :
             off == REG_RX_PORTS ? {recv_dest_port, recv_src_port} :
             off == REG_RX_LEN   ? {16'b0, recv_length} :
             off == REG_IRQ_EN   ? irq_rd : '0;
    rd_data = win == WIN_REG             ? reg_rd :
              (win == WIN_SEND && k_ok) ? send_buf[{ki, 5'b0} +: 32] :
              (win == WIN_RECV && k_ok) ? recv_buf[{ki, 5'b0} +: 32] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata      <= '0;
      bus_rvalid     <= 1'b0;
      self_mac       <= DEFAULT_MAC;
      self_ip        <= DEFAULT_IP;
      gateway_ip     <= DEFAULT_IP;
      send_dest_ip   <= '0;
      send_src_port  <= '0;
      send_dest_port <= '0;
      send_length    <= '0;
      send_buf       <= '0;
      rx_valid       <= 1'b0;
      rx_overflow    <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re) bus_rdata <= rd_data;
      if (wr_reg && off == REG_MAC_LO) self_mac[31:0] <= bus_wdata;
      if (wr_reg && off == REG_MAC_HI) self_mac[47:32] <= bus_wdata[15:0];
      // send-side fields freeze while a send is in flight
      if (wr_reg && !tx_busy && off == REG_SELF_IP) self_ip <= bus_wdata;
      if (wr_reg && !tx_busy && off == REG_GW_IP) gateway_ip <= bus_wdata;
      if (wr_reg && !tx_busy && off == REG_DEST_IP) send_dest_ip <= bus_wdata;
      if (wr_reg && !tx_busy && off == REG_TX_PORTS) {send_dest_port, send_src_port} <= bus_wdata;
      if (wr_reg && !tx_busy && off == REG_TX_LEN) send_length <= bus_wdata[15:0];
      if (bus_we && win == WIN_SEND && k_ok && !tx_busy) send_buf[{ki, 5'b0} +: 32] <= bus_wdata;
      rx_valid    <= recv_complete || (rx_valid && !ack);
      rx_overflow <= drop || (rx_overflow && !clr);
      drop_cnt    <= drop ? (drop_cnt == 8'hFF ? drop_cnt : drop_cnt + 8'd1) : clr ? '0 : drop_cnt;
    end
  end
`ifdef ETH_MMIO_IRQ_EN
  logic [2:0] irq_en;
  logic       tx_done_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en         <= '0;
      tx_done_sticky <= 1'b0;
      irq            <= 1'b0;
    end else begin
      if (wr_reg && off == REG_IRQ_EN) irq_en <= bus_wdata[2:0];
      tx_done_sticky <= tx_done ? 1'b1 : (ctrl_wr && bus_wdata[CTRL_CLR_DONE]) ? 1'b0 : tx_done_sticky;
      irq            <= |(irq_en & {len_err | rx_overflow, tx_done_sticky, rx_valid});
    end
  end
  assign irq_rd    = {29'b0, irq_en};
  assign unused_ok = ^bus_addr[1:0];
`else
  assign irq_rd    = '0;
  assign unused_ok = ^{bus_addr[1:0], tx_done};
`endif
endmodule

// File: tb/tb_eth_mmio_regs.sv
// tb_eth_mmio_regs: directed self-checking bench for eth_mmio_regs
module tb_eth_mmio_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [47:0] self_mac;
  logic [31:0] self_ip, gateway_ip, send_dest_ip;
  logic [15:0] send_src_port, send_dest_port, send_length;
  logic        send_trigger;
  logic [1023:0] send_buf;
  logic [1023:0] recv_buf = '0;
  logic [15:0] recv_src_port = '0, recv_dest_port = '0, recv_length = '0;
  logic        recv_complete = 1'b0;
  logic [1:0]  linkspeed = 2'b00;
  logic        recv_buf_full;
  int checks = 0, passed = 0, fails = 0;
  int cyc = 0;
  int t0, hi;
  eth_mmio_regs dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .self_mac(self_mac), .self_ip(self_ip), .gateway_ip(gateway_ip), .send_dest_ip(send_dest_ip),
    .send_src_port(send_src_port), .send_dest_port(send_dest_port), .send_length(send_length),
    .send_trigger(send_trigger), .send_buf(send_buf), .recv_buf(recv_buf),
    .recv_src_port(recv_src_port), .recv_dest_port(recv_dest_port), .recv_length(recv_length),
    .recv_complete(recv_complete), .linkspeed(linkspeed), .recv_buf_full(recv_buf_full)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus_addr = a;
    bus_wdata = d;
    bus_we = 1'b1;
    @(posedge clk);
    #1 bus_we = 1'b0;
    @(negedge clk);
  endtask
  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
    bus_addr = a;
    bus_re = 1'b1;
    @(posedge clk);
    #1 bus_re = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    chk(tag, bus_rdata, e);
    @(negedge clk);
  endtask
  task automatic rc_pulse();
    recv_complete = 1'b1;
    @(posedge clk);
    #1 recv_complete = 1'b0;
    @(negedge clk);
  endtask
  task automatic count_trig(input int n, output int h);
    h = 0;
    repeat (n) begin
      h += int'(send_trigger);
      @(negedge clk);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_trigger", 32'(send_trigger), 32'd0);
    chk("rst_rbf", 32'(recv_buf_full), 32'd0);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_send_buf", send_buf[31:0], 32'd0);
    rd(12'h008, 32'h3501_0203, "mac_lo");
    @(posedge clk);
    #1 chk("rvalid_single", 32'(bus_rvalid), 32'd0);
    @(negedge clk);
    rd(12'h00C, 32'h0000_000A, "mac_hi");
    rd(12'h004, 32'h0, "status_rst");
    rd(12'h010, 32'hC0A8_0102, "self_ip");
    rd(12'h014, 32'hC0A8_0102, "gw_ip");
    rd(12'h000, 32'h0, "ctrl_read");
    rd(12'h02C, 32'h0, "irq_en_absent");
    rd(12'h030, 32'h0, "unmapped");
    rd(12'hC00, 32'h0, "win11");
    wr(12'h400, 32'hDEAD_BEEF);
    chk("send_buf_w0", send_buf[31:0], 32'hDEAD_BEEF);
    rd(12'h400, 32'hDEAD_BEEF, "send_win_rd");
    wr(12'h020, 32'd4);
    wr(12'h000, 32'h1);
    t0 = cyc;
    count_trig(8, hi);
    chk("trig_len", 32'(hi), 32'd4);
    wr(12'h000, 32'h1);
    count_trig(8, hi);
    chk("send_while_busy", 32'(hi), 32'd0);
    wr(12'h020, 32'd7);
    wr(12'h400, 32'h1234_5678);
    chk("send_buf_locked", send_buf[31:0], 32'hDEAD_BEEF);
    rd(12'h020, 32'd4, "txlen_locked");
    while (cyc < t0 + 4099) @(negedge clk);
    rd(12'h004, 32'h1, "busy_last");
    rd(12'h004, 32'h0, "busy_done");
    bus_addr = 12'h018;
    bus_wdata = 32'hAABB_CCDD;
    bus_we = 1'b1;
    bus_re = 1'b1;
    @(posedge clk);
    #1 bus_we = 1'b0;
    bus_re = 1'b0;
    chk("rw_same_old", bus_rdata, 32'h0);
    @(negedge clk);
    rd(12'h018, 32'hAABB_CCDD, "rw_same_new");
    wr(12'h020, 32'd0);
    wr(12'h000, 32'h1);
    chk("len0_trig", 32'(send_trigger), 32'd0);
    rd(12'h004, 32'h8, "len0_err");
    wr(12'h000, 32'h4);
    rd(12'h004, 32'h0, "clr_err");
    wr(12'h020, 32'd129);
    wr(12'h000, 32'h1);
    chk("len129_trig", 32'(send_trigger), 32'd0);
    rd(12'h004, 32'h8, "len129_err");
    wr(12'h000, 32'h4);
    rd(12'h004, 32'h0, "clr_err2");
    linkspeed = 2'b10;
    recv_buf[31:0] = 32'hCAFE_F00D;
    recv_buf[63:32] = 32'h1122_3344;
    recv_length = 16'd12;
    recv_src_port = 16'h1234;
    recv_dest_port = 16'h5678;
    rc_pulse();
    chk("rx_rbf_set", 32'(recv_buf_full), 32'd1);
    rd(12'h004, 32'h22, "rx_status");
    rd(12'h028, 32'd12, "rx_len");
    rd(12'h024, 32'h5678_1234, "rx_ports");
    rd(12'h800, 32'hCAFE_F00D, "recv_w0");
    rd(12'h804, 32'h1122_3344, "recv_w1");
    rd(12'h880, 32'h0, "recv_oob");
    wr(12'h000, 32'h2);
    chk("rx_ack_rbf", 32'(recv_buf_full), 32'd0);
    rd(12'h004, 32'h20, "rx_acked");
    rc_pulse();
    rc_pulse();
    rc_pulse();
    rd(12'h004, 32'h0002_0026, "overflow");
    bus_addr = 12'h000;
    bus_wdata = 32'h2;
    bus_we = 1'b1;
    recv_complete = 1'b1;
    @(posedge clk);
    #1 bus_we = 1'b0;
    recv_complete = 1'b0;
    @(negedge clk);
    chk("ack_rc_rbf", 32'(recv_buf_full), 32'd1);
    rd(12'h004, 32'h0002_0026, "ack_rc_status");
    repeat (260) rc_pulse();
    rd(12'h004, 32'h00FF_0026, "drop_sat");
    wr(12'h000, 32'h4);
    rd(12'h004, 32'h22, "clr_drop");
    wr(12'h000, 32'h2);
    rd(12'h004, 32'h20, "final_ack");
    linkspeed = 2'b00;
    wr(12'h020, 32'd128);
    wr(12'h000, 32'h1);
    chk("len128_trig", 32'(send_trigger), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_trig", 32'(send_trigger), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'h004, 32'h0, "status_after_rst");
    rd(12'h020, 32'h0, "txlen_after_rst");
    chk("send_buf_after_rst", send_buf[31:0], 32'h0);
    chk("trig_after_rst", 32'(send_trigger), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
